// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
//   state_t  : transmitter FSM states
//   PAR_*    : parity-mode encodings for the PARITY parameter
//   clog2    : ceiling log2, used to size counters and pointers
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous TX FIFO with registered occupancy.
//   clk, rst        : clock, async active-low reset
//   push, push_data : write request; accepted when not full or popping this cycle
//   pop             : remove head entry (caller guarantees not empty)
//   head            : current head entry
//   count           : number of stored entries
//   full, empty     : occupancy flags
module uart_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head,
   output logic [clog2(DEPTH):0]   count,
   output logic                    full,
   output logic                    empty
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_nxt;
   logic             push_ok;
   logic             pop_ok;

   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok) begin
         count_nxt = count + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_nxt = count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count_nxt;
         full  <= (count_nxt == DEPTH_C);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes queue into a FIFO and are serialised
// start / data (LSB first) / optional parity / stop, gated on cts.
//   clk, rst  : clock, async active-low reset
//   wr_en     : write strobe, wr_data queued when accepted
//   cts       : clear-to-send, checked only when a frame could start
//   full      : FIFO full
//   count     : FIFO occupancy
//   overflow  : one-cycle pulse for a write dropped because the FIFO was full
//   busy      : transmitter not idle
//   rts       : high for the whole frame, start bit through last stop bit
//   txd       : serial output, idle high
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, waiting for queued data and cts
// ST_START  | start bit (low) for one bit period
// ST_DATA   | DATA_BITS data bits, LSB first
// ST_PARITY | parity bit (never entered when PARITY is none)
// ST_STOP   | stop bit(s) high; may chain directly into the next START
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [DATA_BITS-1:0]        wr_data,
   input  logic                        cts,
   output logic                        full,
   output logic [clog2(FIFO_DEPTH):0]  count,
   output logic                        overflow,
   output logic                        busy,
   output logic                        rts,
   output logic                        txd
);

   if (BAUD_DIV < 2) begin : g_chk_baud
      $error("uart_tx_fifo: BAUD_DIV must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data
      $error("uart_tx_fifo: DATA_BITS must be 5..8");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_chk_par
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
   end

   localparam int BCW = clog2(STOP_BITS * BAUD_DIV);
   localparam int BTW = clog2(DATA_BITS);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(BAUD_DIV - 1);
   localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS * BAUD_DIV - 1);
   localparam logic [BTW-1:0] DATA_LAST = BTW'(DATA_BITS - 1);

   state_t               state;
   state_t               state_nxt;
   logic [BCW-1:0]       baud_cnt;
   logic [BCW-1:0]       baud_nxt;
   logic [BTW-1:0]       bit_cnt;
   logic [BTW-1:0]       bit_nxt;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_nxt;
   logic [DATA_BITS-1:0] head;
   logic                 par_q;
   logic                 par_nxt;
   logic                 head_par;
   logic                 txd_nxt;
   logic                 pop;
   logic                 start_ok;
   logic                 fifo_empty;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (fifo_empty)
   );

   assign start_ok = !fifo_empty && cts;
   // Parity is fixed when the byte is loaded so the shifter can be consumed freely.
   assign head_par = (PARITY == PAR_ODD) ? ~(^head) : (^head);
   assign busy     = (state != ST_IDLE);

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt + BCW'(1);
      bit_nxt   = bit_cnt;
      shift_nxt = shift_q;
      par_nxt   = par_q;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            baud_nxt = '0;
            if (start_ok) begin
               pop       = 1'b1;
               shift_nxt = head;
               par_nxt   = head_par;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (baud_cnt == BIT_LAST) begin
               baud_nxt  = '0;
               bit_nxt   = '0;
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_cnt == BIT_LAST) begin
               baud_nxt = '0;
               if (bit_cnt == DATA_LAST) begin
                  state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_nxt   = bit_cnt + BTW'(1);
                  shift_nxt = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_cnt == BIT_LAST) begin
               baud_nxt  = '0;
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (baud_cnt == STOP_LAST) begin
               baud_nxt = '0;
               // Chaining straight into START keeps queued frames gap-free.
               if (start_ok) begin
                  pop       = 1'b1;
                  shift_nxt = head;
                  par_nxt   = head_par;
                  state_nxt = ST_START;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            baud_nxt  = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // txd is derived from the next state so the pin is a clean flop output.
   always_comb begin
      txd_nxt = 1'b1;
      case (state_nxt)
         ST_START:  txd_nxt = 1'b0;
         ST_DATA:   txd_nxt = shift_nxt[0];
         ST_PARITY: txd_nxt = par_nxt;
         default:   txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         txd      <= 1'b1;
         rts      <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
         shift_q  <= shift_nxt;
         par_q    <= par_nxt;
         txd      <= txd_nxt;
         rts      <= (state_nxt != ST_IDLE);
         overflow <= wr_en && full && !pop;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations share one stimulus stream,
// each checked every cycle against a queue-based line model, plus literal
// frame expectations.
module tb_uart_tx_fifo;

   localparam int NCFG  = 4;
   localparam int BAUD  = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic cts = 1'b0;

   logic [NCFG-1:0] full_v, ovf_v, busy_v, rts_v, txd_v;
   logic [NCFG-1:0][CW-1:0] count_v;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   logic [NCFG-1:0] rec [64];
   int rts_cnt [NCFG];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int DB  = (g == 3) ? 7 : 8;
      localparam int PAR = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
      localparam int SB  = (g == 3) ? 2 : 1;

      logic [7:0] fifo_q [$];
      logic       wave [$];
      logic       exp_ovf = 1'b0;

      uart_tx_fifo #(
         .BAUD_DIV   (BAUD),
         .DATA_BITS  (DB),
         .PARITY     (PAR),
         .STOP_BITS  (SB),
         .FIFO_DEPTH (DEPTH)
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (wr_en),
         .wr_data  (wr_data[DB-1:0]),
         .cts      (cts),
         .full     (full_v[g]),
         .count    (count_v[g]),
         .overflow (ovf_v[g]),
         .busy     (busy_v[g]),
         .rts      (rts_v[g]),
         .txd      (txd_v[g])
      );

      // Line model: wave holds the txd level for each upcoming clock of the frame.
      initial begin
         int n;
         bit pop_now;
         logic [7:0] b;
         int ones;
         logic pb;
         forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
               fifo_q.delete();
               wave.delete();
               exp_ovf = 1'b0;
            end else begin
               n = fifo_q.size();
               pop_now = 1'b0;
               if (wave.size() != 0) void'(wave.pop_front());
               if (wave.size() == 0 && n != 0 && cts) begin
                  b = fifo_q.pop_front();
                  pop_now = 1'b1;
                  ones = $countones(b);
                  repeat (BAUD) wave.push_back(1'b0);
                  for (int i = 0; i < DB; i++) repeat (BAUD) wave.push_back(b[i]);
                  if (PAR != 0) begin
                     pb = (PAR == 2) ? ones[0] : ~ones[0];
                     repeat (BAUD) wave.push_back(pb);
                  end
                  repeat (SB * BAUD) wave.push_back(1'b1);
               end
               exp_ovf = wr_en && (n == DEPTH) && !pop_now;
               if (wr_en && (n < DEPTH || pop_now))
                  fifo_q.push_back(wr_data & 8'((1 << DB) - 1));
            end
         end
      end

      initial begin
         logic e_txd;
         logic e_act;
         logic e_full;
         logic [CW-1:0] e_cnt;
         forever begin
            @(negedge clk);
            if (chk_en) begin
               e_txd  = (wave.size() != 0) ? wave[0] : 1'b1;
               e_act  = (wave.size() != 0);
               e_cnt  = CW'(fifo_q.size());
               e_full = (fifo_q.size() == DEPTH);
               checks++;
               if (txd_v[g] !== e_txd || rts_v[g] !== e_act || busy_v[g] !== e_act ||
                   full_v[g] !== e_full || ovf_v[g] !== exp_ovf || count_v[g] !== e_cnt) begin
                  errors++;
                  $display("FAIL cycle_cmp cfg%0d t=%0t got txd=%b rts=%b busy=%b full=%b ovf=%b count=%0d want txd=%b rts=%b busy=%b full=%b ovf=%b count=%0d",
                           g, $time, txd_v[g], rts_v[g], busy_v[g], full_v[g], ovf_v[g], count_v[g],
                           e_txd, e_act, e_act, e_full, exp_ovf, e_cnt);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
      end
   endtask

   function automatic logic [10:0] frame_bits(input int g);
      logic [10:0] v;
      v = '0;
      for (int j = 0; j < 11; j++) v[j] = rec[j * BAUD + 1][g];
      return v;
   endfunction

   // Writes one byte at a negedge and records txd for 64 clocks after the write edge.
   task automatic send_rec(input logic [7:0] d);
      for (int g = 0; g < NCFG; g++) rts_cnt[g] = 0;
      wr_en = 1'b1;
      wr_data = d;
      @(posedge clk); #1;
      check("wr_lat_count", count_v[0], 1);
      check("wr_lat_txd_high", txd_v, 4'hf);
      @(negedge clk);
      wr_en = 1'b0;
      for (int k = 0; k < 64; k++) begin
         @(posedge clk); #1;
         rec[k] = txd_v;
         for (int g = 0; g < NCFG; g++) rts_cnt[g] += int'(rts_v[g]);
      end
      check("txd_fall_edge_e1", rec[0], 4'h0);
      check("line_idle_after", rec[63], 4'hf);
      @(negedge clk);
   endtask

   initial begin
      logic [10:0] fb;
      int cnt;
      int guard;
      logic r;

      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_txd", txd_v, 4'hf);
      check("rst_rts", rts_v, 4'h0);
      check("rst_busy", busy_v, 4'h0);
      check("rst_full", full_v, 4'h0);
      check("rst_ovf", ovf_v, 4'h0);
      check("rst_count", count_v[0], 0);
      rst = 1'b1;
      cts = 1'b1;
      @(negedge clk);

      send_rec(8'h55);
      fb = frame_bits(0);
      check("frame55_8n1", fb[9:0], 10'h2AA);
      check("rts_len_8n1", rts_cnt[0], 40);

      send_rec(8'h07);
      fb = frame_bits(1);
      check("frame07_even", fb, 11'h60E);
      fb = frame_bits(2);
      check("frame07_odd", fb, 11'h40E);
      check("rts_len_8e1", rts_cnt[1], 44);

      send_rec(8'h41);
      fb = frame_bits(3);
      check("frame41_7n2", fb[9:0], 10'h382);
      check("rts_len_7n2", rts_cnt[3], 40);

      // Fill with cts low, then release and expect back-to-back frames.
      cts = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1;
         wr_data = 8'(8'h11 * (i + 1));
         @(posedge clk); #1;
         if (i == 3) check("full_after_4", full_v[0], 1);
         if (i == 4) begin
            check("ovf_pulse", ovf_v[0], 1);
            check("count_full", count_v[0], 4);
         end
         @(negedge clk);
      end
      wr_en = 1'b0;
      @(posedge clk); #1;
      check("ovf_one_cycle", ovf_v[0], 0);
      @(negedge clk);
      cts = 1'b1;
      @(posedge clk); #1;
      cnt = 0;
      guard = 0;
      while (rts_v[0] === 1'b1 && guard < 400) begin
         cnt++;
         guard++;
         @(posedge clk); #1;
      end
      check("b2b_rts_len", cnt, 160);
      check("b2b_drained", count_v[0], 0);
      repeat (40) @(negedge clk);

      // cts drop mid-frame with data still queued.
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1;
         wr_data = 8'(8'hA1 + 17 * i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      repeat (10) @(negedge clk);
      cts = 1'b0;
      repeat (150) @(negedge clk);
      check("cts_hold_txd", txd_v, 4'hf);
      check("cts_hold_rts", rts_v, 4'h0);
      check("cts_hold_count", count_v[0], 2);
      cts = 1'b1;
      @(posedge clk); #1;
      check("cts_restart", txd_v, 4'h0);
      repeat (200) @(negedge clk);

      // Asynchronous reset in the middle of a data bit.
      wr_en = 1'b1;
      wr_data = 8'h3C;
      @(negedge clk);
      wr_data = 8'h5A;
      @(negedge clk);
      wr_en = 1'b0;
      repeat (12) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_txd", txd_v, 4'hf);
      check("arst_rts", rts_v, 4'h0);
      check("arst_busy", busy_v, 4'h0);
      check("arst_count", count_v[0], 0);
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         cnt += int'(|rts_v);
      end
      check("post_rst_silent", cnt, 0);

      // Randomised traffic with cts toggling and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         wr_en = ($urandom_range(0, 99) < 35);
         wr_data = 8'($urandom);
         if ($urandom_range(0, 99) < 3) cts = ~cts;
         r = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
         rst = r;
      end
      @(negedge clk);
      rst = 1'b1;
      wr_en = 1'b0;
      cts = 1'b1;
      repeat (300) @(negedge clk);
      check("final_count", count_v[0], 0);
      check("final_idle", busy_v, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, buffered UART transmitter and the next generation of the board-level `uart` TX block.
- Accepts bytes through a write-strobe interface into an internal FIFO.
- Serialises them with programmable data bits, parity, stop bits and bit period.
- Gates frame starts on a CTS input and drives RTS while a frame is on the line.
- Sits between the user-logic/button-switch front end and the board's `txd`/`rts` pins.

Parameters:
- BAUD_DIV, 16: clocks per serial bit; ≥2.
- DATA_BITS, 8: data bits per frame; 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, ≥2.

Ports:
- clk  in  1: system clock; all logic on rising edge.
- rst  in  1: reset; asynchronous, active-low.
- wr_en  in  1: write strobe; one byte per cycle.
- wr_data  in  DATA_BITS: byte to queue.
- cts  in  1: clear-to-send; high = a frame may start.
- full  out  1: FIFO full; writes ignored.
- count  out  clog2(FIFO_DEPTH)+1: FIFO occupancy.
- overflow  out  1: one-cycle pulse when wr_en is seen while full and no pop occurs that cycle.
- busy  out  1: high whenever not in IDLE.
- rts  out  1: high from start bit through the last stop bit.
- txd  out  1: serial line; idle high.

Behaviour:
- Reset (rst low, async): txd=1, rts=0, busy=0, full=0, count=0, overflow=0, state IDLE, baud counter 0, FIFO pointers 0.
  - Reset mid-frame aborts at once; txd returns high with no glitch low.
  - Queued data is discarded.
- FIFO:
  - Write accepted when wr_en && (!full || pop in the same cycle).
  - Pop happens only on the frame-start decision.
  - Simultaneous write and pop leaves count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
  - count, full and overflow are registered.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if count≠0 && cts, pop the head into the shift register; next state START.
  - START: txd=0 for BAUD_DIV clocks.
  - DATA: DATA_BITS bits, LSB first, each BAUD_DIV clocks.
  - PARITY: skipped when PARITY=0. Odd: bit makes total ones in data+parity odd. Even: XOR of the data bits.
  - STOP: txd=1 for STOP_BITS*BAUD_DIV clocks.
  - End of STOP: if count≠0 && cts, pop and go directly to START (no idle gap); else IDLE.
- Timing:
  - Baud counter restarts at 0 on every state entry.
  - Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV clocks.
  - Write latency: byte written at edge E into an empty FIFO while idle with cts=1 gives count=1 after E; txd falls and rts/busy rise after edge E+1.
- txd and rts are registered outputs, with no combinational path from inputs.
- cts is sampled only at frame-start decisions. Dropping cts mid-frame does not truncate the frame; no new frame starts until cts is high.
- rts=0 and busy=0 in IDLE.
- Out-of-range parameters are an elaboration error.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - clog2 helper function.
- Sub-module uart_fifo (DATA_BITS wide, FIFO_DEPTH deep): synchronous FIFO with count/full/empty outputs.
- Baud counter, shifter and FSM stay in uart_tx_fifo.

Test Plan:
1. BAUD_DIV=4, PARITY=0, cts=1; write 0x55 → txd 0,1,0,1,0,1,0,1,0,1 at 4 clocks each. txd falls one clock after the write registers. rts high exactly 40 clocks, then txd=1, busy=0.
2. PARITY=2, write 0x07 → parity bit 1. PARITY=1, write 0x07 → parity bit 0. Frame is 11 bits = 44 clocks.
3. cts=0; write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles → full after 4th; 5th gives one overflow pulse; count=4. Raise cts → 0x11..0x44 sent back to back with no idle cycle between stop and start bits; count decrements on each frame start.
4. cts dropped during the data bits of frame 1 with 2 queued → frame 1 completes intact; line idles high. Raise cts → next frame starts one clock later.
5. rst low mid-data bit → txd=1, rts=0, count=0 immediately without a clock. After release, no frame is sent.
6. DATA_BITS=7, STOP_BITS=2, PARITY=0, write 0x41 → bits 0,1,0,0,0,0,0,1,1,1; 10 bits × BAUD_DIV clocks.
